// File: rtl/btn_debounce_ctrl.sv
// btn_debounce_ctrl: two-channel push-button conditioner.
// Each raw button is passed through a 2-FF synchroniser and a four-state
// debounce FSM with a DB_BITS-bit down-time counter. A clean press produces
// a one-cycle tick, and that tick toggles the run-enable or direction level.
// Optional feature macro: BTN_BOTH_CLEAR_EN. When it is defined, holding
// both buttons at once forces en_out low and cw_out back to CW_INIT.

// One debounce channel: synchroniser, FSM and stability counter.
//   state | meaning
//   ZERO  | input settled low
//   WAIT1 | input went high, waiting for 2^DB_BITS stable cycles
//   ONE   | input settled high
//   WAIT0 | input went low, waiting for 2^DB_BITS stable cycles
module btn_db_channel #(
  parameter int DB_BITS = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic level_o,
  output logic tick_o,
  output logic accept_o
);

  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

  localparam logic [DB_BITS-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic [DB_BITS-1:0]   cnt_q, cnt_d;
  logic                 sync1_q, sync2_q;
  logic                 level_q, level_d;
  logic                 tick_q, tick_d;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // State, counter, and registered level and tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ZERO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      tick_q  <= tick_d;
    end
  end

  // Next-state logic. The counter is only compared while waiting; a bounce
  // back to the settled value abandons the count, and the count is cleared
  // again on the next entry to a wait state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    case (state_q)
      ZERO: begin
        if (sync2_q) begin
          state_d = WAIT1;
          cnt_d   = '0;
        end
      end
      WAIT1: begin
        if (!sync2_q) begin
          state_d = ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ONE;
          tick_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ONE: begin
        if (!sync2_q) begin
          state_d = WAIT0;
          cnt_d   = '0;
        end
      end
      WAIT0: begin
        if (sync2_q) begin
          state_d = ONE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ZERO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ZERO;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == ONE) || (state_d == WAIT0);
  end

  assign level_o  = level_q;
  assign tick_o   = tick_q;
  assign accept_o = tick_d;

endmodule

// Top level: two debounce channels and the toggled control levels.
module btn_debounce_ctrl #(
  parameter int   DB_BITS = 20,
  parameter logic CW_INIT = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_run_raw,
  input  logic btn_dir_raw,
  output logic en_out,
  output logic cw_out,
  output logic run_level,
  output logic dir_level,
  output logic run_tick,
  output logic dir_tick
);

  logic run_accept, dir_accept;
  logic en_q, en_d;
  logic cw_q, cw_d;

  btn_db_channel #(.DB_BITS(DB_BITS)) u_run (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw_i    (btn_run_raw),
    .level_o  (run_level),
    .tick_o   (run_tick),
    .accept_o (run_accept)
  );

  btn_db_channel #(.DB_BITS(DB_BITS)) u_dir (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw_i    (btn_dir_raw),
    .level_o  (dir_level),
    .tick_o   (dir_tick),
    .accept_o (dir_accept)
  );

  // Toggle on the same edge that registers each tick high.
  always_comb begin
    en_d = en_q ^ run_accept;
    cw_d = cw_q ^ dir_accept;
`ifdef BTN_BOTH_CLEAR_EN
    if (run_level && dir_level) begin
      en_d = 1'b0;
      cw_d = CW_INIT;
    end
`endif
  end

  // Control level registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q <= 1'b0;
      cw_q <= CW_INIT;
    end else begin
      en_q <= en_d;
      cw_q <= cw_d;
    end
  end

  assign en_out = en_q;
  assign cw_out = cw_q;

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// Directed bench for btn_debounce_ctrl with DB_BITS=4 (18-edge latency).
// Output vector packing: {run_level, dir_level, run_tick, dir_tick, en_out, cw_out}.
module tb_btn_debounce_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_run_raw = 1'b0;
  logic btn_dir_raw = 1'b0;
  logic en_out, cw_out, run_level, dir_level, run_tick, dir_tick;

  int n_checks = 0;
  int n_errors = 0;
  int run_tick_cnt = 0;
  int dir_tick_cnt = 0;

  typedef struct {
    string       name;
    logic        run;
    logic        dir;
    int          cyc;
    logic [5:0]  exp;
  } vec_t;

  vec_t cp_vecs[$];
  vec_t rp_vecs[$];

  btn_debounce_ctrl #(.DB_BITS(4), .CW_INIT(1'b1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_run_raw (btn_run_raw),
    .btn_dir_raw (btn_dir_raw),
    .en_out      (en_out),
    .cw_out      (cw_out),
    .run_level   (run_level),
    .dir_level   (dir_level),
    .run_tick    (run_tick),
    .dir_tick    (dir_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (run_tick) run_tick_cnt++;
    if (dir_tick) dir_tick_cnt++;
  end

  function automatic logic [5:0] o(logic rl, logic dl, logic rt, logic dt, logic en, logic cw);
    return {rl, dl, rt, dt, en, cw};
  endfunction

  function automatic vec_t mk(string name, logic run, logic dir, int cyc, logic [5:0] exp);
    vec_t v;
    v.name = name; v.run = run; v.dir = dir; v.cyc = cyc; v.exp = exp;
    return v;
  endfunction

  function automatic logic [5:0] outs();
    return {run_level, dir_level, run_tick, dir_tick, en_out, cw_out};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (rl dl rt dt en cw)", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vecs(input vec_t vs[$]);
    foreach (vs[i]) begin
      btn_run_raw = vs[i].run;
      btn_dir_raw = vs[i].dir;
      step(vs[i].cyc);
      chk(vs[i].name, outs(), vs[i].exp);
    end
  endtask

  task automatic do_reset();
    btn_run_raw = 1'b0;
    btn_dir_raw = 1'b0;
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  initial begin
    int base;
    logic ena, enb;

    cp_vecs.push_back(mk("cp_pre",      1'b1, 1'b0, 18, o(0,0,0,0,0,1)));
    cp_vecs.push_back(mk("cp_tick",     1'b1, 1'b0,  1, o(1,0,1,0,1,1)));
    cp_vecs.push_back(mk("cp_tick_end", 1'b1, 1'b0,  1, o(1,0,0,0,1,1)));
    cp_vecs.push_back(mk("cp_hold",     1'b1, 1'b0, 20, o(1,0,0,0,1,1)));
    cp_vecs.push_back(mk("cp_rel_pre",  1'b0, 1'b0, 18, o(1,0,0,0,1,1)));
    cp_vecs.push_back(mk("cp_rel",      1'b0, 1'b0,  1, o(0,0,0,0,1,1)));
    cp_vecs.push_back(mk("cp_idle",     1'b0, 1'b0, 10, o(0,0,0,0,1,1)));

    for (int p = 0; p < 3; p++) begin
      ena = (p % 2 == 0);
      enb = ~ena;
      rp_vecs.push_back(mk($sformatf("rp%0d_pre", p),     1'b1, 1'b0, 18, o(0,0,0,0,enb,1)));
      rp_vecs.push_back(mk($sformatf("rp%0d_tick", p),    1'b1, 1'b0,  1, o(1,0,1,0,ena,1)));
      rp_vecs.push_back(mk($sformatf("rp%0d_hold", p),    1'b1, 1'b0, 11, o(1,0,0,0,ena,1)));
      rp_vecs.push_back(mk($sformatf("rp%0d_rel_pre", p), 1'b0, 1'b0, 18, o(1,0,0,0,ena,1)));
      rp_vecs.push_back(mk($sformatf("rp%0d_low", p),     1'b0, 1'b0, 12, o(0,0,0,0,ena,1)));
    end

    // Reset behaviour
    reset_n = 1'b0;
    step(3);
    chk("rst_hold", outs(), o(0,0,0,0,0,1));
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(1);
      chk($sformatf("rst_idle%0d", i), outs(), o(0,0,0,0,0,1));
    end

    // Clean press and release
    base = run_tick_cnt;
    run_vecs(cp_vecs);
    chk_int("cp_tick_count", run_tick_cnt - base, 1);

    // Bounce rejection on the direction button
    do_reset();
    base = dir_tick_cnt;
    for (int i = 0; i < 12; i++) begin
      btn_dir_raw = (i % 2 == 0);
      step(5);
    end
    chk_int("bn_no_tick", dir_tick_cnt - base, 0);
    chk("bn_settled", outs(), o(0,0,0,0,0,1));
    btn_dir_raw = 1'b1;
    step(18);
    chk("bn_pre", outs(), o(0,0,0,0,0,1));
    step(1);
    chk("bn_tick", outs(), o(0,1,0,1,0,0));
    step(10);
    chk("bn_hold", outs(), o(0,1,0,0,0,0));
    chk_int("bn_tick_count", dir_tick_cnt - base, 1);

    // Repeated presses
    do_reset();
    base = run_tick_cnt;
    run_vecs(rp_vecs);
    chk_int("rp_tick_count", run_tick_cnt - base, 3);

    // Reset in the middle of a debounce (counter at 9)
    do_reset();
    base = run_tick_cnt;
    btn_run_raw = 1'b1;
    step(12);
    chk("rm_before", outs(), o(0,0,0,0,0,1));
    reset_n = 1'b0;
    #2;
    chk("rm_in_reset", outs(), o(0,0,0,0,0,1));
    #2;
    reset_n = 1'b1;
    step(18);
    chk("rm_pre", outs(), o(0,0,0,0,0,1));
    step(1);
    chk("rm_tick", outs(), o(1,0,1,0,1,1));
    step(5);
    chk("rm_hold", outs(), o(1,0,0,0,1,1));
    chk_int("rm_tick_count", run_tick_cnt - base, 1);

    // Simultaneous presses
    do_reset();
    btn_run_raw = 1'b1;
    btn_dir_raw = 1'b1;
    step(18);
    chk("sim_pre", outs(), o(0,0,0,0,0,1));
    step(1);
    chk("sim_tick", outs(), o(1,1,1,1,1,0));
    step(1);
`ifdef BTN_BOTH_CLEAR_EN
    chk("sim_clear", outs(), o(1,1,0,0,0,1));
    step(5);
    chk("sim_clear_hold", outs(), o(1,1,0,0,0,1));
`else
    chk("sim_after", outs(), o(1,1,0,0,1,0));
    step(5);
    chk("sim_hold", outs(), o(1,1,0,0,1,0));
`endif
    btn_run_raw = 1'b0;
    btn_dir_raw = 1'b0;
    step(30);
`ifdef BTN_BOTH_CLEAR_EN
    chk("sim_release", outs(), o(0,0,0,0,0,1));
`else
    chk("sim_release", outs(), o(0,0,0,0,1,0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
